// File: rtl/combat_if.sv
// Signal bundle between the game logic and the combat controller.
// The master drives the frame tick and player inputs; the slave returns health, flags, FSM state and timer.
interface combat_if;
  logic       frame_tick;
  logic       start;
  logic       p1_attack;
  logic       p2_attack;
  logic       p1_colliding;
  logic       p2_colliding;
  logic [4:0] health_l;
  logic [4:0] health_r;
  logic       p1_attacking;
  logic       p2_attacking;
  logic       p1_stun;
  logic       p2_stun;
  logic [1:0] state;
  logic [1:0] winner;
  logic [6:0] round_time;

  modport master (
    output frame_tick, start, p1_attack, p2_attack, p1_colliding, p2_colliding,
    input  health_l, health_r, p1_attacking, p2_attacking, p1_stun, p2_stun,
           state, winner, round_time
  );

  modport slave (
    input  frame_tick, start, p1_attack, p2_attack, p1_colliding, p2_colliding,
    output health_l, health_r, p1_attacking, p2_attacking, p1_stun, p2_stun,
           state, winner, round_time
  );
endinterface

// File: rtl/combat_controller.sv
// Two-player combat FSM (IDLE/FIGHT/KO) with cooldown, hitstun and health, updated once per frame_tick.
// Optional round timer: define ROUND_TIMER_EN to enable a 99-second timeout.
module combat_controller #(
  parameter int MAX_HEALTH      = 31,
  parameter int DAMAGE          = 4,
  parameter int COOLDOWN_FRAMES = 20,
  parameter int ACTIVE_FRAMES   = 6,
  parameter int HITSTUN_FRAMES  = 10
) (
  input logic     clk,
  input logic     reset,
  combat_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_FIGHT = 2'b01, S_KO = 2'b10} state_t;

  localparam logic [4:0] HMAX   = 5'(MAX_HEALTH);
  localparam logic [4:0] DMG    = 5'(DAMAGE);
  localparam logic [7:0] CD_LD  = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] ATK_TH = 8'(COOLDOWN_FRAMES - ACTIVE_FRAMES);
  localparam logic [7:0] ST_LD  = 8'(HITSTUN_FRAMES);

  state_t     r_state, w_state_nx;
  logic [4:0] r_hl, r_hr, w_hl_nx, w_hr_nx;
  logic [7:0] r_cd1, r_cd2, r_st1, r_st2;
  logic [7:0] w_cd1_nx, w_cd2_nx, w_st1_nx, w_st2_nx;
  logic [1:0] r_win, w_win_nx;
  logic       r_a1, r_a2, r_s1, r_s2;
  logic       w_acc1, w_acc2;
`ifdef ROUND_TIMER_EN
  logic [6:0] r_rt, w_rt_nx;
  logic [5:0] r_fc, w_fc_nx;
`endif

  function automatic logic [7:0] dec8(input logic [7:0] v);
    return (v == 8'd0) ? v : v - 8'd1;
  endfunction

  function automatic logic [4:0] hit(input logic [4:0] h);
    return (h > DMG) ? h - DMG : 5'd0;
  endfunction

  // Higher health wins; equal (including both zero) is a draw.
  function automatic logic [1:0] judge(input logic [4:0] hl, input logic [4:0] hr);
    if (hl == hr)     return 2'b11;
    else if (hl > hr) return 2'b01;
    else              return 2'b10;
  endfunction

  always_comb begin
    w_state_nx = r_state;
    w_hl_nx    = r_hl;
    w_hr_nx    = r_hr;
    w_cd1_nx   = r_cd1;
    w_cd2_nx   = r_cd2;
    w_st1_nx   = r_st1;
    w_st2_nx   = r_st2;
    w_win_nx   = r_win;
    w_acc1     = 1'b0;
    w_acc2     = 1'b0;
`ifdef ROUND_TIMER_EN
    w_rt_nx    = r_rt;
    w_fc_nx    = r_fc;
`endif
    if (bus.frame_tick) begin
      w_cd1_nx = dec8(r_cd1);
      w_cd2_nx = dec8(r_cd2);
      w_st1_nx = dec8(r_st1);
      w_st2_nx = dec8(r_st2);
      unique case (r_state)
        S_IDLE, S_KO: begin
          if (bus.start) begin
            w_state_nx = S_FIGHT;
            w_hl_nx    = HMAX;
            w_hr_nx    = HMAX;
            w_cd1_nx   = 8'd0;
            w_cd2_nx   = 8'd0;
            w_st1_nx   = 8'd0;
            w_st2_nx   = 8'd0;
            w_win_nx   = 2'b00;
`ifdef ROUND_TIMER_EN
            w_rt_nx    = 7'd99;
            w_fc_nx    = 6'd0;
`endif
          end
        end
        S_FIGHT: begin
          w_acc1 = bus.p1_attack && (r_cd1 == 8'd0) && (r_st1 == 8'd0);
          w_acc2 = bus.p2_attack && (r_cd2 == 8'd0) && (r_st2 == 8'd0);
          if (w_acc1) w_cd1_nx = CD_LD;
          if (w_acc2) w_cd2_nx = CD_LD;
          // Both landings are evaluated from pre-tick state so a trade is symmetric.
          if (w_acc1 && bus.p1_colliding) begin
            w_hr_nx  = hit(r_hr);
            w_st2_nx = ST_LD;
          end
          if (w_acc2 && bus.p2_colliding) begin
            w_hl_nx  = hit(r_hl);
            w_st1_nx = ST_LD;
          end
          if ((w_hl_nx == 5'd0) || (w_hr_nx == 5'd0)) begin
            w_state_nx = S_KO;
            w_win_nx   = judge(w_hl_nx, w_hr_nx);
          end
`ifdef ROUND_TIMER_EN
          else if (r_fc == 6'd59) begin
            w_fc_nx = 6'd0;
            w_rt_nx = r_rt - 7'd1;
            if (r_rt == 7'd1) begin
              w_state_nx = S_KO;
              w_win_nx   = judge(w_hl_nx, w_hr_nx);
            end
          end else begin
            w_fc_nx = r_fc + 6'd1;
          end
`endif
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hl    <= HMAX;
      r_hr    <= HMAX;
      r_cd1   <= 8'd0;
      r_cd2   <= 8'd0;
      r_st1   <= 8'd0;
      r_st2   <= 8'd0;
      r_win   <= 2'b00;
      r_a1    <= 1'b0;
      r_a2    <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
`ifdef ROUND_TIMER_EN
      r_rt    <= 7'd99;
      r_fc    <= 6'd0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_hl    <= w_hl_nx;
      r_hr    <= w_hr_nx;
      r_cd1   <= w_cd1_nx;
      r_cd2   <= w_cd2_nx;
      r_st1   <= w_st1_nx;
      r_st2   <= w_st2_nx;
      r_win   <= w_win_nx;
      r_a1    <= (w_cd1_nx > ATK_TH);
      r_a2    <= (w_cd2_nx > ATK_TH);
      r_s1    <= (w_st1_nx != 8'd0);
      r_s2    <= (w_st2_nx != 8'd0);
`ifdef ROUND_TIMER_EN
      r_rt    <= w_rt_nx;
      r_fc    <= w_fc_nx;
`endif
    end
  end

  assign bus.state        = r_state;
  assign bus.health_l     = r_hl;
  assign bus.health_r     = r_hr;
  assign bus.winner       = r_win;
  assign bus.p1_attacking = r_a1;
  assign bus.p2_attacking = r_a2;
  assign bus.p1_stun      = r_s1;
  assign bus.p2_stun      = r_s2;
`ifdef ROUND_TIMER_EN
  assign bus.round_time   = r_rt;
`else
  assign bus.round_time   = 7'd0;
`endif
endmodule

// File: tb/tb_combat_controller.sv
// Randomized and directed bench for combat_controller: a frame-level game model feeds an
// expected-output queue that a free-running monitor compares against the DUT every cycle.
module tb_combat_controller;
  localparam int MAXH = 31;
  localparam int DMG  = 4;
  localparam int CD   = 20;
  localparam int ACT  = 6;
  localparam int HS   = 10;
`ifdef ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  combat_if bus();

  combat_controller #(
    .MAX_HEALTH(MAXH), .DAMAGE(DMG), .COOLDOWN_FRAMES(CD),
    .ACTIVE_FRAMES(ACT), .HITSTUN_FRAMES(HS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [24:0] exp_q[$];

  // Game model: 0 idle, 1 fight, 2 ko; winner 0 none, 1 p1, 2 p2, 3 draw.
  int m_state, m_hl, m_hr, m_cd1, m_cd2, m_st1, m_st2, m_win, m_rt, m_frames;

  function automatic int judge(input int hl, input int hr);
    if (hl == hr) return 3;
    return (hl > hr) ? 1 : 2;
  endfunction

  function automatic int drain(input int v);
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic new_round(input int st);
    m_state = st;
    m_hl = MAXH; m_hr = MAXH;
    m_cd1 = 0; m_cd2 = 0; m_st1 = 0; m_st2 = 0;
    m_win = 0; m_frames = 0;
    m_rt = TIMER ? 99 : 0;
  endtask

  task automatic model_step(input logic rst, tk, st, a1, a2, c1, c2);
    bit ok1, ok2;
    if (rst) begin
      new_round(0);
    end else if (tk) begin
      ok1 = (m_state == 1) && a1 && m_cd1 == 0 && m_st1 == 0;
      ok2 = (m_state == 1) && a2 && m_cd2 == 0 && m_st2 == 0;
      m_cd1 = drain(m_cd1); m_cd2 = drain(m_cd2);
      m_st1 = drain(m_st1); m_st2 = drain(m_st2);
      if (m_state != 1) begin
        if (st) new_round(1);
      end else begin
        if (ok1) m_cd1 = CD;
        if (ok2) m_cd2 = CD;
        if (ok1 && c1) begin m_hr = (m_hr > DMG) ? m_hr - DMG : 0; m_st2 = HS; end
        if (ok2 && c2) begin m_hl = (m_hl > DMG) ? m_hl - DMG : 0; m_st1 = HS; end
        if (m_hl == 0 || m_hr == 0) begin
          m_state = 2; m_win = judge(m_hl, m_hr);
        end else if (TIMER) begin
          m_frames++;
          if (m_frames == 60) begin
            m_frames = 0; m_rt--;
            if (m_rt == 0) begin m_state = 2; m_win = judge(m_hl, m_hr); end
          end
        end
      end
    end
  endtask

  function automatic logic [24:0] model_pack();
    return {2'(m_state), 2'(m_win), 5'(m_hl), 5'(m_hr),
            (m_cd1 > CD - ACT), (m_cd2 > CD - ACT), (m_st1 != 0), (m_st2 != 0), 7'(m_rt)};
  endfunction

  function automatic logic [24:0] dut_pack();
    return {bus.state, bus.winner, bus.health_l, bus.health_r,
            bus.p1_attacking, bus.p2_attacking, bus.p1_stun, bus.p2_stun, bus.round_time};
  endfunction

  // Driver: one call = one clock cycle; outputs are settled when it returns.
  task automatic step(input logic rst, tk, st, a1, a2, c1, c2);
    @(negedge clk);
    reset = rst; bus.frame_tick = tk; bus.start = st;
    bus.p1_attack = a1; bus.p2_attack = a2; bus.p1_colliding = c1; bus.p2_colliding = c2;
    model_step(rst, tk, st, a1, a2, c1, c2);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #2;
  endtask

  // A game tick followed by a non-tick cycle with the same inputs held.
  task automatic tick(input logic st, a1, a2, c1, c2);
    step(1'b0, 1'b1, st, a1, a2, c1, c2);
    step(1'b0, 1'b0, st, a1, a2, c1, c2);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every cycle's registered outputs against the model's queued expectation.
  initial begin
    logic [24:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = dut_pack();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t: got st=%0d win=%0d hl=%0d hr=%0d flags=%b rt=%0d, expected st=%0d win=%0d hl=%0d hr=%0d flags=%b rt=%0d",
                   $time, a[24:23], a[22:21], a[20:16], a[15:11], a[10:7], a[6:0],
                   e[24:23], e[22:21], e[20:16], e[15:11], e[10:7], e[6:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_a, n_s1, n_s2;
    reset = 1'b1;
    bus.frame_tick = 1'b0; bus.start = 1'b0;
    bus.p1_attack = 1'b0; bus.p2_attack = 1'b0; bus.p1_colliding = 1'b0; bus.p2_colliding = 1'b0;
    new_round(0);

    step(1, 1, 1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("reset_state", bus.state, 0);
    chk("reset_health_l", bus.health_l, MAXH);
    chk("reset_winner", bus.winner, 0);
    chk("reset_round_time", bus.round_time, TIMER ? 99 : 0);

    // Single landed hit, then active and hitstun windows.
    tick(1, 0, 0, 0, 0);
    chk("start_fight", bus.state, 1);
    tick(0, 1, 0, 1, 0);
    chk("hit_health_r", bus.health_r, 27);
    chk("hit_p2_stun", bus.p2_stun, 1);
    n_a = bus.p1_attacking; n_s2 = bus.p2_stun;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, 0);
      n_a += bus.p1_attacking; n_s2 += bus.p2_stun;
    end
    chk("p1_active_ticks", n_a, ACT);
    chk("p2_stun_ticks", n_s2, HS);

    // Held attack with collision for 25 ticks lands exactly twice.
    step(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) tick(0, 1, 0, 1, 0);
    chk("held_attack_health_r", bus.health_r, 23);

    // Simultaneous trade.
    step(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 1, 1, 1);
    chk("trade_health_l", bus.health_l, 27);
    chk("trade_health_r", bus.health_r, 27);
    n_s1 = bus.p1_stun; n_s2 = bus.p2_stun;
    for (int i = 0; i < 12; i++) begin
      tick(0, 0, 0, 0, 0);
      n_s1 += bus.p1_stun; n_s2 += bus.p2_stun;
    end
    chk("trade_p1_stun_ticks", n_s1, HS);
    chk("trade_p2_stun_ticks", n_s2, HS);

    // Player 2 beats player 1 down to KO, attacks then ignored, restart.
    step(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 400 && bus.state != 2; i++) tick(0, 0, 1, 0, 1);
    chk("ko_state", bus.state, 2);
    chk("ko_health_l", bus.health_l, 0);
    chk("ko_winner", bus.winner, 2);
    for (int i = 0; i < 25; i++) tick(0, 1, 1, 1, 1);
    chk("ko_frozen_health_r", bus.health_r, MAXH);
    chk("ko_frozen_winner", bus.winner, 2);
    tick(1, 0, 0, 0, 0);
    chk("restart_state", bus.state, 1);
    chk("restart_health_l", bus.health_l, MAXH);
    chk("restart_winner", bus.winner, 0);

    // Reset coincident with a tick carrying a landing hit.
    step(1, 1, 0, 1, 0, 1, 0);
    chk("rst_hit_state", bus.state, 0);
    chk("rst_hit_health_r", bus.health_r, MAXH);
    tick(0, 1, 0, 1, 0);
    chk("idle_no_fight", bus.state, 0);
    chk("idle_health_r", bus.health_r, MAXH);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

    // Long fight at 31/27: timeout with the timer, endless fight without.
    step(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(0, 1, 0, 1, 0);
    for (int i = 0; i < 5939; i++) tick(0, 0, 0, 0, 0);
    chk("long_health_r", bus.health_r, 27);
    chk("long_round_time", bus.round_time, 0);
    chk("long_state", bus.state, TIMER ? 2 : 1);
    chk("long_winner", bus.winner, TIMER ? 1 : 0);

    step(0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
